// File: rtl/stopwatch_counter.sv
// stopwatch_counter: MM:SS stopwatch time base feeding the 7-segment display driver.
//   Keeps four BCD digits with run/pause, clear and a carry-free manual adjust mode.
//   All outputs are registered; a tick, clear or pause shows up one cycle after its pulse.
// Ports:
//   clk, rst_n        - clock and asynchronous active-low reset
//   tick_1hz          - 1 Hz enable, advances time in RUN
//   tick_adj          - 2 Hz enable, bumps the selected field in ADJUST
//   pause, clear      - one-cycle debounced pulses (toggle run/pause, zero time)
//   adj, sel          - levels: adjust mode enable, field select (0 = minutes, 1 = seconds)
//   min_l..sec_r      - BCD digits, zero-extended to DIG_W bits
//   running, wrap     - RUN indicator, one-cycle pulse on MAX_MIN:59 -> 00:00 rollover
module stopwatch_counter #(
  parameter int MAX_MIN = 59,
  parameter int DIG_W   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick_1hz,
  input  logic             tick_adj,
  input  logic             pause,
  input  logic             clear,
  input  logic             adj,
  input  logic             sel,
  output logic [DIG_W-1:0] min_l,
  output logic [DIG_W-1:0] min_r,
  output logic [DIG_W-1:0] sec_l,
  output logic [DIG_W-1:0] sec_r,
  output logic             running,
  output logic             wrap
);

  typedef enum logic [1:0] {
    ST_STOP = 2'd0,
    ST_RUN  = 2'd1,
    ST_ADJ  = 2'd2
  } state_t;

  localparam logic [3:0] MAX_ML = 4'(MAX_MIN / 10);
  localparam logic [3:0] MAX_MR = 4'(MAX_MIN % 10);

  state_t     state;
  logic [3:0] ml, mr, sl, sr;

  // Incremented copies of each field; shared by RUN counting and ADJUST bumping.
  logic [3:0] sl_inc, sr_inc, ml_inc, mr_inc;
  logic       sec_last, min_last;

  always_comb begin
    sec_last = (sl == 4'd5) && (sr == 4'd9);
    min_last = (ml == MAX_ML) && (mr == MAX_MR);

    sr_inc = (sr == 4'd9) ? 4'd0 : sr + 4'd1;
    sl_inc = sl;
    if (sr == 4'd9) begin
      sl_inc = (sl == 4'd5) ? 4'd0 : sl + 4'd1;
    end

    ml_inc = ml;
    mr_inc = mr + 4'd1;
    if (min_last) begin
      ml_inc = 4'd0;
      mr_inc = 4'd0;
    end else if (mr == 4'd9) begin
      ml_inc = ml + 4'd1;
      mr_inc = 4'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_STOP;
      running <= 1'b0;
      wrap    <= 1'b0;
      ml      <= 4'd0;
      mr      <= 4'd0;
      sl      <= 4'd0;
      sr      <= 4'd0;
    end else begin
      wrap <= 1'b0;
      if (clear) begin
        // Clear wins over everything else; state is left as it is.
        ml <= 4'd0;
        mr <= 4'd0;
        sl <= 4'd0;
        sr <= 4'd0;
      end else if (state != ST_ADJ && adj) begin
        state   <= ST_ADJ;
        running <= 1'b0;
      end else if (state == ST_ADJ && !adj) begin
        // Leaving adjust always lands in STOP so the user must restart explicitly.
        state   <= ST_STOP;
        running <= 1'b0;
      end else if (pause && state == ST_STOP) begin
        state   <= ST_RUN;
        running <= 1'b1;
      end else if (pause && state == ST_RUN) begin
        state   <= ST_STOP;
        running <= 1'b0;
      end else if (state == ST_RUN && tick_1hz) begin
        sr <= sr_inc;
        sl <= sl_inc;
        if (sec_last) begin
          ml   <= ml_inc;
          mr   <= mr_inc;
          wrap <= min_last;
        end
      end else if (state == ST_ADJ && tick_adj) begin
        // Fields bump independently; no carry between seconds and minutes.
        if (sel) begin
          sr <= sr_inc;
          sl <= sl_inc;
        end else begin
          ml <= ml_inc;
          mr <= mr_inc;
        end
      end
    end
  end

  assign min_l = DIG_W'(ml);
  assign min_r = DIG_W'(mr);
  assign sec_l = DIG_W'(sl);
  assign sec_r = DIG_W'(sr);

endmodule

// File: tb/tb_stopwatch_counter.sv
module tb_stopwatch_counter;

  localparam int MAX_MIN = 59;
  localparam int DIG_W   = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tick_1hz = 1'b0, tick_adj = 1'b0, pause = 1'b0, clear = 1'b0, adj = 1'b0, sel = 1'b0;
  logic [DIG_W-1:0] min_l, min_r, sec_l, sec_r;
  logic running, wrap;

  stopwatch_counter #(.MAX_MIN(MAX_MIN), .DIG_W(DIG_W)) dut (
    .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz), .tick_adj(tick_adj),
    .pause(pause), .clear(clear), .adj(adj), .sel(sel),
    .min_l(min_l), .min_r(min_r), .sec_l(sec_l), .sec_r(sec_r),
    .running(running), .wrap(wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          seg;
    logic        t1, ta, p, c, a, s;
    logic [15:0] bcd;
    logic        run, wr;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   mm = 0;
  int   ss = 0;

  function automatic vec_t mk(int seg, logic t1, logic ta, logic p, logic c, logic a, logic s,
                              logic [15:0] bcd, logic run, logic wr);
    vec_t v;
    v.seg = seg; v.t1 = t1; v.ta = ta; v.p = p; v.c = c; v.a = a; v.s = s;
    v.bcd = bcd; v.run = run; v.wr = wr;
    return v;
  endfunction

  function automatic logic [15:0] to_bcd(int m, int s);
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  task automatic check(string name, logic [15:0] bcd, logic run, logic wr);
    logic [4*DIG_W-1:0] exp_d, act_d;
    exp_d = {DIG_W'(bcd[15:12]), DIG_W'(bcd[11:8]), DIG_W'(bcd[7:4]), DIG_W'(bcd[3:0])};
    act_d = {min_l, min_r, sec_l, sec_r};
    n_vec++;
    if (act_d !== exp_d) begin
      n_bad++;
      $display("FAIL %s digits: got %0d%0d:%0d%0d want %0d%0d:%0d%0d", name,
               min_l, min_r, sec_l, sec_r, bcd[15:12], bcd[11:8], bcd[7:4], bcd[3:0]);
    end
    if (running !== run) begin
      n_bad++;
      $display("FAIL %s running: got %b want %b", name, running, run);
    end
    if (wrap !== wr) begin
      n_bad++;
      $display("FAIL %s wrap: got %b want %b", name, wrap, wr);
    end
  endtask

  task automatic cyc(logic t1, logic ta, logic p, logic c, logic a, logic s);
    @(negedge clk);
    tick_1hz = t1; tick_adj = ta; pause = p; clear = c; adj = a; sel = s;
    @(posedge clk);
    #1;
  endtask

  task automatic run_seg(int k);
    int last;
    last = -1;
    foreach (tbl[i]) begin
      if (tbl[i].seg == k) begin
        cyc(tbl[i].t1, tbl[i].ta, tbl[i].p, tbl[i].c, tbl[i].a, tbl[i].s);
        check($sformatf("seg%0d_row%0d", k, i), tbl[i].bcd, tbl[i].run, tbl[i].wr);
        last = i;
      end
    end
    if (last >= 0) begin
      mm = int'(tbl[last].bcd[15:12]) * 10 + int'(tbl[last].bcd[11:8]);
      ss = int'(tbl[last].bcd[7:4]) * 10 + int'(tbl[last].bcd[3:0]);
    end
  endtask

  // Stay in ADJUST and bump one field n times (s: 0 = minutes, 1 = seconds).
  task automatic adj_ticks(logic s, int n);
    for (int i = 0; i < n; i++) begin
      if (s) ss = (ss + 1) % 60;
      else   mm = (mm + 1) % (MAX_MIN + 1);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, s);
      check($sformatf("adj_preload_s%0b_%0d", s, i), to_bcd(mm, ss), 1'b0, 1'b0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  initial begin
    // seg 1: from 01:15 RUN -- clear, tick+clear at 00:09, adjust entry/exit, pause corners
    tbl.push_back(mk(1, 0,0,0,1,0,0, 16'h0000, 1, 0));
    tbl.push_back(mk(1, 1,0,0,0,0,0, 16'h0001, 1, 0));
    tbl.push_back(mk(1, 1,0,0,0,0,0, 16'h0002, 1, 0));
    tbl.push_back(mk(1, 1,0,0,0,0,0, 16'h0003, 1, 0));
    tbl.push_back(mk(1, 1,0,0,0,0,0, 16'h0004, 1, 0));
    tbl.push_back(mk(1, 1,0,0,0,0,0, 16'h0005, 1, 0));
    tbl.push_back(mk(1, 1,0,0,0,0,0, 16'h0006, 1, 0));
    tbl.push_back(mk(1, 1,0,0,0,0,0, 16'h0007, 1, 0));
    tbl.push_back(mk(1, 1,0,0,0,0,0, 16'h0008, 1, 0));
    tbl.push_back(mk(1, 1,0,0,0,0,0, 16'h0009, 1, 0));
    tbl.push_back(mk(1, 1,0,0,1,0,0, 16'h0000, 1, 0));  // tick discarded by clear
    tbl.push_back(mk(1, 1,0,0,0,0,0, 16'h0001, 1, 0));
    tbl.push_back(mk(1, 0,0,0,0,0,0, 16'h0001, 1, 0));
    tbl.push_back(mk(1, 1,0,0,0,1,1, 16'h0001, 0, 0));  // enter ADJUST, tick ignored
    tbl.push_back(mk(1, 0,1,1,0,1,1, 16'h0002, 0, 0));  // pause ignored, tick_adj counts
    tbl.push_back(mk(1, 0,0,0,0,0,1, 16'h0002, 0, 0));  // exit to STOP
    tbl.push_back(mk(1, 1,0,0,0,0,0, 16'h0002, 0, 0));  // STOP holds
    tbl.push_back(mk(1, 0,0,1,0,0,0, 16'h0002, 1, 0));
    tbl.push_back(mk(1, 1,0,1,0,0,0, 16'h0002, 0, 0));  // pause beats tick
    tbl.push_back(mk(1, 0,0,0,0,1,1, 16'h0002, 0, 0));  // into ADJUST for preload
    // seg 2: from 00:58 ADJUST, seconds field wrap and minutes bump
    tbl.push_back(mk(2, 0,1,0,0,1,1, 16'h0059, 0, 0));
    tbl.push_back(mk(2, 0,1,0,0,1,1, 16'h0000, 0, 0));
    tbl.push_back(mk(2, 0,1,0,0,1,1, 16'h0001, 0, 0));
    tbl.push_back(mk(2, 0,1,0,0,1,0, 16'h0101, 0, 0));
    tbl.push_back(mk(2, 1,0,0,0,1,0, 16'h0101, 0, 0));  // tick_1hz no effect in ADJUST
    // seg 3: from 59:01 ADJUST, minutes field wraps, seconds untouched, no wrap pulse
    tbl.push_back(mk(3, 0,1,0,0,1,0, 16'h0001, 0, 0));
    // seg 4: from 59:58 ADJUST -- run through the full rollover
    tbl.push_back(mk(4, 0,0,0,0,0,0, 16'h5958, 0, 0));
    tbl.push_back(mk(4, 0,0,1,0,0,0, 16'h5958, 1, 0));
    tbl.push_back(mk(4, 1,0,0,0,0,0, 16'h5959, 1, 0));
    tbl.push_back(mk(4, 1,0,0,0,0,0, 16'h0000, 1, 1));
    tbl.push_back(mk(4, 0,0,0,0,0,0, 16'h0000, 1, 0));
    tbl.push_back(mk(4, 1,0,0,0,0,0, 16'h0001, 1, 0));
    tbl.push_back(mk(4, 0,0,0,0,1,0, 16'h0001, 0, 0));
    // seg 5: from 12:34 ADJUST -- pause with tick, ticks in STOP, clear beats adj
    tbl.push_back(mk(5, 0,0,0,0,0,0, 16'h1234, 0, 0));
    tbl.push_back(mk(5, 0,0,1,0,0,0, 16'h1234, 1, 0));
    tbl.push_back(mk(5, 1,0,1,0,0,0, 16'h1234, 0, 0));
    for (int i = 0; i < 5; i++) tbl.push_back(mk(5, 1,0,0,0,0,0, 16'h1234, 0, 0));
    tbl.push_back(mk(5, 0,0,0,1,1,0, 16'h0000, 0, 0));  // clear wins, stays STOP
    tbl.push_back(mk(5, 0,0,1,0,0,0, 16'h0000, 1, 0));  // pause only works from STOP
    tbl.push_back(mk(5, 1,0,0,0,0,0, 16'h0001, 1, 0));
    tbl.push_back(mk(5, 1,0,0,0,0,0, 16'h0002, 1, 0));
    // seg 6: after async reset -- ticks ignored until pause
    for (int i = 0; i < 3; i++) tbl.push_back(mk(6, 1,0,0,0,0,0, 16'h0000, 0, 0));
    tbl.push_back(mk(6, 0,0,1,0,0,0, 16'h0000, 1, 0));
    tbl.push_back(mk(6, 1,0,0,0,0,0, 16'h0001, 1, 0));

    // Reset is asserted from time 0; outputs must already be cleared before any edge.
    #2;
    check("reset_state", 16'h0000, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Start and count 75 seconds: 00:00 -> 01:15, no wrap.
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("start_run", 16'h0000, 1'b1, 1'b0);
    mm = 0; ss = 0;
    for (int i = 0; i < 75; i++) begin
      ss++;
      if (ss == 60) begin ss = 0; mm++; end
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check($sformatf("run75_%0d", i), to_bcd(mm, ss), 1'b1, 1'b0);
    end
    check("run75_final", 16'h0115, 1'b1, 1'b0);

    run_seg(1);
    adj_ticks(1'b1, 56);   // 00:02 -> 00:58
    run_seg(2);
    adj_ticks(1'b0, 58);   // 01:01 -> 59:01
    run_seg(3);
    adj_ticks(1'b0, 59);   // 00:01 -> 59:01
    adj_ticks(1'b1, 57);   // 59:01 -> 59:58
    run_seg(4);
    adj_ticks(1'b0, 12);   // 00:01 -> 12:01
    adj_ticks(1'b1, 33);   // 12:01 -> 12:34
    run_seg(5);

    // Asynchronous reset between edges while running at 00:02.
    #2;
    tick_1hz = 1'b0; tick_adj = 1'b0; pause = 1'b0; clear = 1'b0; adj = 1'b0; sel = 1'b0;
    rst_n = 1'b0;
    #1;
    check("async_reset", 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    run_seg(6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
